hazard_pipe_tracker: RTL and testbench

- Producer side of the forwarding path.
- Keeps a shadow copy of destination-register info (rd, Regwrite, Memread) as it moves ID/EX -> EX/MEM -> MEM/WB.
- Drives the ex_mem_*/mem_wb_* signals that forwarding_unit consumes.
- Resolves the hazards forwarding cannot cover: load-use stall and taken-branch flush. It generates PC/IF-ID write enables and ID/EX bubble control for the 5-stage pipeline.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_pipe_tracker_if.sv | 45 ++++
 rtl/dest_shadow_stage.sv | 21 ++
 rtl/hazard_pipe_tracker.sv | 124 ++++++++++++
 tb/tb_hazard_pipe_tracker.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, hazard-state encoding,
// and the destination-register shadow record carried down the pipe.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } shadow_t;

endpackage : pipe_pkg

// File: rtl/hazard_pipe_tracker_if.sv
// Signal bundle between the ID-stage instruction source and the hazard
// tracker: ID operand/destination info in, pipeline control and tracked
// destinations out.
interface hazard_pipe_tracker_if;
  import pipe_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] if_id_Rs1;
  logic [REG_ADDR_W-1:0] if_id_Rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_Regwrite;
  logic                  id_Memread;
  logic                  branch_taken;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  flush_if_id;
  logic                  id_ex_bubble;
  logic [REG_ADDR_W-1:0] id_ex_rd;
  logic [REG_ADDR_W-1:0] ex_mem_rd;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic                  id_ex_Memread;
  logic                  ex_mem_Regwrite;
  logic                  mem_wb_Regwrite;
  logic [1:0]            hz_state;

  modport master (
    output id_valid, if_id_Rs1, if_id_Rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_Regwrite, id_Memread, branch_taken,
    input  pc_write, if_id_write, flush_if_id, id_ex_bubble,
           id_ex_rd, ex_mem_rd, mem_wb_rd, id_ex_Memread,
           ex_mem_Regwrite, mem_wb_Regwrite, hz_state
  );

  modport slave (
    input  id_valid, if_id_Rs1, if_id_Rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_Regwrite, id_Memread, branch_taken,
    output pc_write, if_id_write, flush_if_id, id_ex_bubble,
           id_ex_rd, ex_mem_rd, mem_wb_rd, id_ex_Memread,
           ex_mem_Regwrite, mem_wb_Regwrite, hz_state
  );

endinterface : hazard_pipe_tracker_if

// File: rtl/dest_shadow_stage.sv
// One pipeline register for the destination-register shadow record.
// 'clear' loads an empty record (bubble) instead of the incoming one.
module dest_shadow_stage
  import pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  shadow_t d,
  output shadow_t q
);

  // Advance the record one stage, or insert an empty one on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every stage samples its predecessor's old value.
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else            q <= d;
  end

endmodule : dest_shadow_stage

// File: rtl/hazard_pipe_tracker.sv
// Hazard tracker for the 5-stage pipeline: shadows rd/Regwrite/Memread
// through ID/EX, EX/MEM, MEM/WB for the forwarding unit and resolves the
// load-use stall and taken-branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_pipe_tracker
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_pipe_tracker_if.slave    bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  shadow_t   id_next;
  shadow_t   id_ex_q;
  shadow_t   ex_mem_q;
  shadow_t   mem_wb_q;
  hz_state_e state_q;
  hz_state_e state_d;
  logic      load_use;
  logic      pc_write;
  logic      if_id_write;
  logic      flush_if_id;
  logic      id_ex_bubble;

  // A consumer in ID needs a value a load in EX has not produced yet.
  assign load_use = bus.id_valid && id_ex_q.memread && (id_ex_q.rd != '0) &&
                    ((bus.id_uses_rs1 && (bus.if_id_Rs1 == id_ex_q.rd)) ||
                     (bus.id_uses_rs2 && (bus.if_id_Rs2 == id_ex_q.rd)));

  // Pipeline control and next hazard state; a taken branch outranks a stall.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    flush_if_id  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = HZ_RUN;
    if (bus.branch_taken) begin
      flush_if_id  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = HZ_FLUSH;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = HZ_STALL;
    end
  end

  // Record entering ID/EX; writes to x0 are never tracked as writes.
  always_comb begin
    id_next          = '0;
    id_next.rd       = bus.id_rd;
    id_next.regwrite = bus.id_Regwrite && (bus.id_rd != '0);
    id_next.memread  = bus.id_Memread;
  end

  dest_shadow_stage u_id_ex (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (id_ex_bubble || !bus.id_valid),
    .d     (id_next),
    .q     (id_ex_q)
  );

  dest_shadow_stage u_ex_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .d     (id_ex_q),
    .q     (ex_mem_q)
  );

  dest_shadow_stage u_mem_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .d     (ex_mem_q),
    .q     (mem_wb_q)
  );

  // Remember last cycle's hazard action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HZ_RUN;
    else        state_q <= state_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters for stalls and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_use && !bus.branch_taken && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (bus.branch_taken && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

  assign bus.pc_write        = pc_write;
  assign bus.if_id_write     = if_id_write;
  assign bus.flush_if_id     = flush_if_id;
  assign bus.id_ex_bubble    = id_ex_bubble;
  assign bus.id_ex_rd        = id_ex_q.rd;
  assign bus.id_ex_Memread   = id_ex_q.memread;
  assign bus.ex_mem_rd       = ex_mem_q.rd;
  assign bus.ex_mem_Regwrite = ex_mem_q.regwrite;
  assign bus.mem_wb_rd       = mem_wb_q.rd;
  assign bus.mem_wb_Regwrite = mem_wb_q.regwrite;
  assign bus.hz_state        = state_q;

endmodule : hazard_pipe_tracker

// File: tb/tb_hazard_pipe_tracker.sv
// Scoreboard bench for hazard_pipe_tracker: the driver pushes the expected
// per-cycle response from a history-based model, a monitor pops and compares.
module tb_hazard_pipe_tracker;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_pipe_tracker_if bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  hazard_pipe_tracker #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    int rd;
    bit rw;
    bit mr;
  } rec_t;

  typedef struct {
    bit pc_write;
    bit if_id_write;
    bit flush;
    bit bubble;
    int id_ex_rd;
    bit id_ex_mr;
    int ex_mem_rd;
    bit ex_mem_rw;
    int mem_wb_rd;
    bit mem_wb_rw;
    int hz;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  // Model state: what entered ID/EX on each of the last three edges.
  rec_t hist[$];
  int   last_action;
  int   m_stall;
  int   m_flush;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    rec_t z = '{0, 0, 0};
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(z);
    last_action = 0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic bit model_load_use();
    rec_t ex = hist[0];
    return bus.id_valid && ex.mr && ex.rd != 0 &&
           ((bus.id_uses_rs1 && int'(bus.if_id_Rs1) == ex.rd) ||
            (bus.id_uses_rs2 && int'(bus.if_id_Rs2) == ex.rd));
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit lu = model_load_use();
    bit br = bus.branch_taken;
    e.flush       = br;
    e.bubble      = br || lu;
    e.pc_write    = br || !lu;
    e.if_id_write = br || !lu;
    e.id_ex_rd    = hist[0].rd;
    e.id_ex_mr    = hist[0].mr;
    e.ex_mem_rd   = hist[1].rd;
    e.ex_mem_rw   = hist[1].rw;
    e.mem_wb_rd   = hist[2].rd;
    e.mem_wb_rw   = hist[2].rw;
    e.hz          = last_action;
    return e;
  endfunction

  function automatic void model_advance();
    bit   lu = model_load_use();
    bit   br = bus.branch_taken;
    rec_t r  = '{0, 0, 0};
    if (bus.id_valid && !br && !lu)
      r = '{int'(bus.id_rd), bus.id_Regwrite && bus.id_rd != 0, bus.id_Memread};
    hist.push_front(r);
    void'(hist.pop_back());
    last_action = br ? 2 : (lu ? 1 : 0);
    if (br) begin
      if (m_flush < CNT_MAX) m_flush++;
    end else if (lu) begin
      if (m_stall < CNT_MAX) m_stall++;
    end
  endfunction

  task automatic set_idle();
    bus.id_valid = 0; bus.if_id_Rs1 = 0; bus.if_id_Rs2 = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd = 0;
    bus.id_Regwrite = 0; bus.id_Memread = 0; bus.branch_taken = 0;
  endtask

  // Drive one cycle of ID inputs (called just after a rising edge).
  task automatic cycle(input bit v, input int rs1, input int rs2, input bit u1,
                       input bit u2, input int rd, input bit rw, input bit mr,
                       input bit br);
    bus.id_valid = v; bus.if_id_Rs1 = 5'(rs1); bus.if_id_Rs2 = 5'(rs2);
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_rd = 5'(rd);
    bus.id_Regwrite = rw; bus.id_Memread = mr; bus.branch_taken = br;
    sb.push_back(model_expect());
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc_write"}, bus.pc_write, 1);
    check({tag, "_if_id_write"}, bus.if_id_write, 1);
    check({tag, "_bubble"}, bus.id_ex_bubble, 0);
    check({tag, "_id_ex_rd"}, bus.id_ex_rd, 0);
    check({tag, "_ex_mem_rd"}, bus.ex_mem_rd, 0);
    check({tag, "_mem_wb_rd"}, bus.mem_wb_rd, 0);
    check({tag, "_mem_wb_rw"}, bus.mem_wb_Regwrite, 0);
    check({tag, "_hz_state"}, bus.hz_state, 0);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt"}, stall_cnt, 0);
    check({tag, "_flush_cnt"}, flush_cnt, 0);
`endif
  endtask

  // Monitor: compare every presented cycle against the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_write", bus.pc_write, e.pc_write);
        check("if_id_write", bus.if_id_write, e.if_id_write);
        check("flush_if_id", bus.flush_if_id, e.flush);
        check("id_ex_bubble", bus.id_ex_bubble, e.bubble);
        check("id_ex_rd", bus.id_ex_rd, e.id_ex_rd);
        check("id_ex_Memread", bus.id_ex_Memread, e.id_ex_mr);
        check("ex_mem_rd", bus.ex_mem_rd, e.ex_mem_rd);
        check("ex_mem_Regwrite", bus.ex_mem_Regwrite, e.ex_mem_rw);
        check("mem_wb_rd", bus.mem_wb_rd, e.mem_wb_rd);
        check("mem_wb_Regwrite", bus.mem_wb_Regwrite, e.mem_wb_rw);
        check("hz_state", bus.hz_state, e.hz);
      end
    end
  end

  initial begin
    set_idle();
    model_reset();
    #2;
    check_reset_state("reset");
    bus.branch_taken = 1;
    #1;
    check("reset_flush_follows_branch", bus.flush_if_id, 1);
    check("reset_bubble_follows_branch", bus.id_ex_bubble, 1);
    bus.branch_taken = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Load-use: load x5 then consumer of x5; one stall cycle, then proceed.
    cycle(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cycle(1, 5, 0, 1, 0, 9, 1, 0, 0);
    cycle(1, 5, 0, 1, 0, 9, 1, 0, 0);
    idle_cycle();
    idle_cycle();
    // Load to x0 followed by consumer of x0: no stall, not tracked as write.
    cycle(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(1, 0, 0, 1, 0, 4, 1, 0, 0);
    idle_cycle();
    // Branch outranks a simultaneous load-use.
    cycle(1, 0, 0, 0, 0, 6, 1, 1, 0);
    cycle(1, 0, 6, 0, 1, 7, 1, 0, 1);
    idle_cycle();
    // ALU chain: producer then consumer via rs2, no stall.
    cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cycle(1, 1, 3, 0, 1, 4, 1, 0, 0);
    idle_cycle();
    idle_cycle();
    // Back-to-back loads, each dependent on the previous.
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 1, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 1, 0);
    cycle(1, 8, 0, 1, 0, 10, 1, 0, 0);
    cycle(1, 8, 0, 1, 0, 10, 1, 0, 0);
    // Matching operand but no valid instruction in ID: no stall.
    cycle(1, 0, 0, 0, 0, 2, 1, 1, 0);
    cycle(0, 2, 2, 1, 1, 0, 0, 0, 0);
    idle_cycle();

    // Reset asserted while a stall is being signalled.
    cycle(1, 0, 0, 0, 0, 5, 1, 1, 0);
    bus.id_valid = 1; bus.if_id_Rs1 = 5; bus.id_uses_rs1 = 1;
    #1;
    check("midstall_pc_write", bus.pc_write, 0);
    #1;
    rst_n = 0;
    #1;
    sb.delete();
    model_reset();
    check_reset_state("midstall_reset");
    set_idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Exactly three stalls and two flushes.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 5, 1, 1, 0);
      cycle(1, 5, 0, 1, 0, 9, 1, 0, 0);
      cycle(1, 5, 0, 1, 0, 9, 1, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 4, 1, 0, 1);
    idle_cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_after_3", stall_cnt, 3);
    check("flush_cnt_after_2", flush_cnt, 2);
`endif

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
    end
    idle_cycle();
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_final", stall_cnt, m_stall);
    check("flush_cnt_final", flush_cnt, m_flush);
`endif
    check("scoreboard_drained", sb.size(), 0);

    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_reset_state("final_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hazard_pipe_tracker
